// File: rtl/fpu_big_alu_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_big_alu_arbiter
//   Shares one combinational signed-magnitude add/sub ALU between two requesters
//   (for example the FP adder and the divider). The arbiter accepts one request
//   at a time with round-robin priority and registers its operands into the ALU.
//   One cycle later it captures the ALU result. It then returns that result on the
//   response channel of the requester that was granted.
//
//   Sequence per operation: IDLE (accept) -> EXEC (ALU settles, capture) ->
//   RESP (hold until the granted requester takes the result) -> IDLE.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/reqN_ready       N=0,1 request handshake
//   reqN_op/a/b/a_sign/b_sign   N=0,1 request operands, sampled only on accept
//   rspN_valid/rspN_ready       N=0,1 response handshake
//   rsp_result/rsp_sign         captured ALU result, shared by both channels
//   alu_op/a/b/a_sign/b_sign    registered operands driving the ALU
//   alu_result/alu_sign         ALU extended result and result sign
//   grant_cnt0/grant_cnt1       saturating accept counters, present only
//                               when FPU_ARB_GRANT_CNT_EN is defined
// -----------------------------------------------------------------------------
module fpu_big_alu_arbiter #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_a_sign,
    input  logic             req0_b_sign,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_a_sign,
    input  logic             req1_b_sign,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH:0]   rsp_result,
    output logic             rsp_sign,
    output logic             alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_a_sign,
    output logic             alu_b_sign,
    input  logic [WIDTH:0]   alu_result,
    input  logic             alu_sign
`ifdef FPU_ARB_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               grant_id_q, grant_id_d;
    logic               alu_op_q, alu_op_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic               alu_a_sign_q, alu_a_sign_d;
    logic               alu_b_sign_q, alu_b_sign_d;
    logic [WIDTH:0]     rsp_result_q, rsp_result_d;
    logic               rsp_sign_q, rsp_sign_d;
    logic               rsp0_valid_q, rsp0_valid_d;
    logic               rsp1_valid_q, rsp1_valid_d;

    logic               sel_any_s;
    logic               sel_id_s;
    logic               accept_s;
    logic               rsp_take_s;

    // Round-robin selection: a lone valid wins, contention goes to the requester not granted last.
    always_comb begin
        sel_any_s = 1'b0;
        sel_id_s  = 1'b0;
        if (req0_valid && req1_valid) begin
            sel_any_s = 1'b1;
            sel_id_s  = ~last_grant_q;
        end else if (req0_valid) begin
            sel_any_s = 1'b1;
            sel_id_s  = 1'b0;
        end else if (req1_valid) begin
            sel_any_s = 1'b1;
            sel_id_s  = 1'b1;
        end else begin
            sel_any_s = 1'b0;
            sel_id_s  = 1'b0;
        end
    end

    // Ready is gated by rst_n so that both readies stay low while reset is asserted.
    assign accept_s   = rst_n && (state_q == ST_IDLE) && sel_any_s;
    assign req0_ready = accept_s && !sel_id_s;
    assign req1_ready = accept_s && sel_id_s;
    assign rsp_take_s = grant_id_q ? rsp1_ready : rsp0_ready;

    // Next-state and datapath: latch operands on accept, capture the result in EXEC, hold in RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_a_sign_d = alu_a_sign_q;
        alu_b_sign_d = alu_b_sign_q;
        rsp_result_d = rsp_result_q;
        rsp_sign_d   = rsp_sign_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    grant_id_d   = sel_id_s;
                    last_grant_d = sel_id_s;
                    alu_op_d     = sel_id_s ? req1_op     : req0_op;
                    alu_a_d      = sel_id_s ? req1_a      : req0_a;
                    alu_b_d      = sel_id_s ? req1_b      : req0_b;
                    alu_a_sign_d = sel_id_s ? req1_a_sign : req0_a_sign;
                    alu_b_sign_d = sel_id_s ? req1_b_sign : req0_b_sign;
                    state_d      = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                rsp_result_d = alu_result;
                rsp_sign_d   = alu_sign;
                rsp0_valid_d = ~grant_id_q;
                rsp1_valid_d = grant_id_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_take_s) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and output registers; last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            alu_op_q     <= 1'b0;
            alu_a_q      <= {WIDTH{1'b0}};
            alu_b_q      <= {WIDTH{1'b0}};
            alu_a_sign_q <= 1'b0;
            alu_b_sign_q <= 1'b0;
            rsp_result_q <= {(WIDTH+1){1'b0}};
            rsp_sign_q   <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_a_sign_q <= alu_a_sign_d;
            alu_b_sign_q <= alu_b_sign_d;
            rsp_result_q <= rsp_result_d;
            rsp_sign_q   <= rsp_sign_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_a_sign = alu_a_sign_q;
    assign alu_b_sign = alu_b_sign_q;
    assign rsp_result = rsp_result_q;
    assign rsp_sign   = rsp_sign_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;

`ifdef FPU_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
    logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;

    // Saturating per-requester accept counters.
    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (accept_s && !sel_id_s && (grant_cnt0_q != {CNT_W{1'b1}})) begin
            grant_cnt0_d = grant_cnt0_q + CNT_W'(1);
        end else begin
            grant_cnt0_d = grant_cnt0_q;
        end
        if (accept_s && sel_id_s && (grant_cnt1_q != {CNT_W{1'b1}})) begin
            grant_cnt1_d = grant_cnt1_q + CNT_W'(1);
        end else begin
            grant_cnt1_d = grant_cnt1_q;
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0_q <= {CNT_W{1'b0}};
            grant_cnt1_q <= {CNT_W{1'b0}};
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule
